cnt_cmd_gen: RTL

- Upstream command stage for the 4-bit up/down counter FSM.
- Turns raw push buttons and data switches into the counter's control inputs: single-cycle CE pulses, a stable UP level, and LOAD strobes with registered DAT_I data.
- Synchronises and debounces every button, arbitrates simultaneous presses, and guarantees at most one command per press.

---
 rtl/cnt_cmd_pkg.sv | 39 +++
 rtl/cnt_cmd_gen_debounce.sv | 57 +++++
 rtl/cnt_cmd_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cnt_cmd_pkg.sv
// ============================================================================
// Module      : cnt_cmd_pkg
// Description : Shared state/command encodings and default timing constants
//               for the counter command generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DN   = 2'd2,
    CMD_LD   = 2'd3
  } cmd_e;

  localparam int unsigned DEF_DB_CYCLES  = 16;
  localparam int unsigned DEF_REP_DELAY  = 64;
  localparam int unsigned DEF_REP_PERIOD = 16;

  // Simultaneous presses resolve as LD > UP > DN.
  function automatic cmd_e pick_cmd(input logic ld, input logic up, input logic dn);
    if (ld)      return CMD_LD;
    else if (up) return CMD_UP;
    else if (dn) return CMD_DN;
    else         return CMD_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_cmd_gen_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : 2-flop synchroniser plus stable-run debouncer for one button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any sample equal to the current level restarts the run.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/cnt_cmd_gen.sv
// ============================================================================
// Module      : cnt_cmd_gen
// Description : Button/switch command stage producing CE, UP, LOAD and DAT_O
//               for the up/down counter. Optional auto-repeat is enabled by
//               defining CNT_CMD_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_cmd_gen
  import cnt_cmd_pkg::*;
#(
  parameter int unsigned W          = 4,
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned REP_DELAY  = DEF_REP_DELAY,
  parameter int unsigned REP_PERIOD = DEF_REP_PERIOD
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BTN_UP,
  input  logic         BTN_DN,
  input  logic         BTN_LD,
  input  logic [W-1:0] SW_I,
  output logic         CE,
  output logic         UP,
  output logic         LOAD,
  output logic [W-1:0] DAT_O,
  output logic         BUSY
);

  if (DB_CYCLES < 2 || REP_PERIOD < 2 || REP_DELAY < 1) begin : g_param_check
    $error("cnt_cmd_gen: DB_CYCLES and REP_PERIOD must be >= 2, REP_DELAY >= 1");
  end

  logic up_db, dn_db, ld_db, any_btn;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (.CLK(CLK), .RST(RST), .btn_i(BTN_UP), .level_o(up_db));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (.CLK(CLK), .RST(RST), .btn_i(BTN_DN), .level_o(dn_db));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ld (.CLK(CLK), .RST(RST), .btn_i(BTN_LD), .level_o(ld_db));

  assign any_btn = up_db | dn_db | ld_db;

  state_e       state_q, state_d;
  cmd_e         cmd_q,   cmd_d;
  logic         ce_q,    ce_d;
  logic         load_q,  load_d;
  logic         up_q,    up_d;
  logic         busy_q,  busy_d;
  logic [W-1:0] dat_q,   dat_d;
  logic [W-1:0] sw_s1_q, sw_s1_d;
  logic [W-1:0] sw_s2_q, sw_s2_d;

`ifdef CNT_CMD_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
  logic           latched_held;

  assign latched_held = ((cmd_q == CMD_UP) && up_db) || ((cmd_q == CMD_DN) && dn_db);
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ce_d    = 1'b0;
    load_d  = 1'b0;
    up_d    = up_q;
    dat_d   = dat_q;
    sw_s1_d = SW_I;
    sw_s2_d = sw_s1_q;
`ifdef CNT_CMD_AUTO_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_btn) begin
          cmd_d   = pick_cmd(ld_db, up_db, dn_db);
          state_d = FIRE;
        end
      end
      FIRE: begin
        case (cmd_q)
          CMD_UP: begin ce_d = 1'b1; up_d = 1'b1; end
          CMD_DN: begin ce_d = 1'b1; up_d = 1'b0; end
          CMD_LD: begin load_d = 1'b1; dat_d = sw_s2_q; end
          default: ;
        endcase
        state_d = HOLD;
`ifdef CNT_CMD_AUTO_REPEAT_EN
        rep_cnt_d = '0;
`endif
      end
`ifdef CNT_CMD_AUTO_REPEAT_EN
      HOLD: begin
        if (!any_btn) begin
          state_d = IDLE;
        end else if (!latched_held) begin
          rep_cnt_d = '0;
        end else if (rep_cnt_q == RCW'(REP_DELAY - 1)) begin
          ce_d      = 1'b1;
          rep_cnt_d = '0;
          state_d   = REPEAT;
        end else begin
          rep_cnt_d = rep_cnt_q + RCW'(1);
        end
      end
      REPEAT: begin
        if (!any_btn) begin
          state_d = IDLE;
        end else if (!latched_held) begin
          rep_cnt_d = '0;
          state_d   = HOLD;
        end else if (rep_cnt_q == RCW'(REP_PERIOD - 1)) begin
          ce_d      = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RCW'(1);
        end
      end
`else
      HOLD: begin
        if (!any_btn) state_d = IDLE;
      end
      REPEAT: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NONE;
      ce_q    <= 1'b0;
      load_q  <= 1'b0;
      up_q    <= 1'b0;
      busy_q  <= 1'b0;
      dat_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
`ifdef CNT_CMD_AUTO_REPEAT_EN
      rep_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ce_q    <= ce_d;
      load_q  <= load_d;
      up_q    <= up_d;
      busy_q  <= busy_d;
      dat_q   <= dat_d;
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
`ifdef CNT_CMD_AUTO_REPEAT_EN
      rep_cnt_q <= rep_cnt_d;
`endif
    end
  end

  assign CE    = ce_q;
  assign LOAD  = load_q;
  assign UP    = up_q;
  assign DAT_O = dat_q;
  assign BUSY  = busy_q;

endmodule

`default_nettype wire
